// File: rtl/intersection_phase_scheduler_if.sv
// Request, configuration and lamp/status bundle between the input
// synchronizers, the phase scheduler and the light/7-segment decoders.
interface intersection_phase_scheduler_if;
    logic       tick;
    logic       req_country;
    logic       req_ped;
    logic       req_emerg;
    logic [3:0] time_green;
    logic [3:0] time_yellow;
    logic [3:0] time_ped;
    logic [2:0] phase;
    logic       highway_red;
    logic       highway_yellow;
    logic       highway_green;
    logic       country_red;
    logic       country_yellow;
    logic       country_green;
    logic       walk;
    logic [3:0] remaining;
    logic       grant_country;
    logic       grant_ped;

    modport master (
        output tick, req_country, req_ped, req_emerg,
        output time_green, time_yellow, time_ped,
        input  phase, highway_red, highway_yellow, highway_green,
        input  country_red, country_yellow, country_green, walk,
        input  remaining, grant_country, grant_ped
    );

    modport slave (
        input  tick, req_country, req_ped, req_emerg,
        input  time_green, time_yellow, time_ped,
        output phase, highway_red, highway_yellow, highway_green,
        output country_red, country_yellow, country_green, walk,
        output remaining, grant_country, grant_ped
    );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Phase sequencer and request arbiter for a highway/country-road crossing
// with a pedestrian walk phase; lamps and counter come from registers only.
module intersection_phase_scheduler (
    input logic                           clock,
    input logic                           reset,
    intersection_phase_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        HG = 3'd0,
        HY = 3'd1,
        AR = 3'd2,
        CG = 3'd3,
        CY = 3'd4,
        PW = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic       pend_country_q, pend_ped_q;
    logic       last_served_q, from_side_q;
    logic       grant_country_q, grant_ped_q;
    logic       done, change, enter_cg, enter_pw, enter_ar;

    // A zero duration would stall the phase forever, so it saturates to one tick.
    function automatic logic [3:0] entry_value(input logic [3:0] cfg);
        return (cfg == 4'd0) ? 4'd1 : cfg;
    endfunction

    assign done     = (remaining_q == 4'd0);
    assign change   = (state_d != state_q);
    assign enter_cg = change && (state_d == CG);
    assign enter_pw = change && (state_d == PW);
    assign enter_ar = change && (state_d == AR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            HG: if (done && (pend_country_q || pend_ped_q) && !bus.req_emerg) state_d = HY;
            HY: if (done) state_d = AR;
            AR: if (done) begin
                    // After a side service the highway always gets a turn first.
                    if (bus.req_emerg || from_side_q)       state_d = HG;
                    else if (pend_country_q && pend_ped_q)  state_d = last_served_q ? CG : PW;
                    else if (pend_country_q)                state_d = CG;
                    else if (pend_ped_q)                    state_d = PW;
                    else                                    state_d = HG;
                end
            CG: if (done || bus.req_emerg) state_d = CY;
            CY: if (done) state_d = AR;
            PW: if (done || bus.req_emerg) state_d = AR;
            default: state_d = HG;
        endcase
    end

    // A state change reloads the counter; a tick on that same edge is dropped.
    always_comb begin
        remaining_d = remaining_q;
        if (change) begin
            case (state_d)
                HG, CG:  remaining_d = entry_value(bus.time_green);
                HY, CY:  remaining_d = entry_value(bus.time_yellow);
                AR:      remaining_d = 4'd1;
                PW:      remaining_d = entry_value(bus.time_ped);
                default: remaining_d = entry_value(bus.time_green);
            endcase
        end else if (bus.tick && !done) begin
            remaining_d = remaining_q - 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= HG;
            remaining_q     <= 4'd0;
            pend_country_q  <= 1'b0;
            pend_ped_q      <= 1'b0;
            last_served_q   <= 1'b0;
            from_side_q     <= 1'b0;
            grant_country_q <= 1'b0;
            grant_ped_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            pend_country_q  <= enter_cg ? 1'b0
                             : (pend_country_q || (bus.req_country && state_q != CG));
            pend_ped_q      <= enter_pw ? 1'b0
                             : (pend_ped_q || (bus.req_ped && state_q != PW));
            grant_country_q <= enter_cg;
            grant_ped_q     <= enter_pw;
            if (enter_cg) last_served_q <= 1'b0;
            if (enter_pw) last_served_q <= 1'b1;
            if (enter_ar) from_side_q <= (state_q == CY) || (state_q == PW);
        end
    end

    always_comb begin
        bus.highway_red    = 1'b1;
        bus.highway_yellow = 1'b0;
        bus.highway_green  = 1'b0;
        bus.country_red    = 1'b1;
        bus.country_yellow = 1'b0;
        bus.country_green  = 1'b0;
        bus.walk           = 1'b0;
        case (state_q)
            HG: begin bus.highway_red = 1'b0; bus.highway_green  = 1'b1; end
            HY: begin bus.highway_red = 1'b0; bus.highway_yellow = 1'b1; end
            CG: begin bus.country_red = 1'b0; bus.country_green  = 1'b1; end
            CY: begin bus.country_red = 1'b0; bus.country_yellow = 1'b1; end
            PW: bus.walk = 1'b1;
            default: ;
        endcase
    end

    assign bus.phase         = state_q;
    assign bus.remaining     = remaining_q;
    assign bus.grant_country = grant_country_q;
    assign bus.grant_ped     = grant_ped_q;
endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Phase sequencer and request arbiter for a two-road intersection with a pedestrian crossing. It collects synchronized service requests from the country-road car sensor, the pedestrian button and the emergency-vehicle preemption input, and arbitrates between them. It then walks the light phases using its own tick-driven down-counter. It sits between the input synchronizers and the light/7-segment decoders, and drives their state and time inputs.

## Interface
Parameters: none; all widths fixed.
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- tick  in  1  single-cycle timebase strobe (1 s); counter moves only on tick
- req_country  in  1  synchronized country-road car present (level)
- req_ped  in  1  synchronized pedestrian request (level or pulse)
- req_emerg  in  1  synchronized emergency preemption (level)
- time_green  in  4  minimum highway green and country green duration, ticks
- time_yellow  in  4  yellow duration, ticks
- time_ped  in  4  walk duration, ticks
- phase  out  3  current state encoding
- highway_red/yellow/green  out  1 each  highway lamps
- country_red/yellow/green  out  1 each  country lamps
- walk  out  1  pedestrian walk lamp
- remaining  out  4  ticks left in current phase (binary, 0–15)
- grant_country  out  1  one-cycle pulse on entry to CG
- grant_ped  out  1  one-cycle pulse on entry to PW

## Operation
- States: HG=0 (highway green), HY=1, AR=2 (all red), CG=3 (country green), CY=4, PW=5 (walk, all vehicles red). Codes 6–7 are illegal and recover to HG on the next edge.
- Lamps, one-hot per road: HG hw green/cty red; HY hw yellow/cty red; AR both red; CG hw red/cty green; CY hw red/cty yellow; PW both red, walk=1.
- Pending registers pend_country and pend_ped:
  - Each sets when its request is high and the block is not in that request's serving state (CG or PW).
  - Each clears on the edge entering its serving state.
- done = (remaining == 0).
- Transitions:
  - HG→HY: done && (pend_country | pend_ped) && !req_emerg. HG holds indefinitely otherwise.
  - HY→AR: done. Emergency does not truncate yellow.
  - AR exit:
    - If req_emerg, go to HG.
    - Else if from_side=1, go to HG.
    - Else choose the service: only one pending → that one. Both pending → the one not equal to last_served. None pending → HG.
  - CG→CY: done || req_emerg.
  - CY→AR: done.
  - PW→AR: done || req_emerg.
- from_side sets on entry to AR from CY or PW, and clears on entry to AR from HY. This guarantees a highway green between any two side services.
- last_served is 0=country, 1=ped. It updates on entry to CG (0) or PW (1).
- Counter:
  - On every state change, remaining loads the entry value: HG/CG: time_green, HY/CY: time_yellow, AR: 1, PW: time_ped.
  - A config value of 0 is loaded as 1.
  - Otherwise remaining decrements on tick while nonzero and holds at 0.
- Outputs are decoded from registered state/counter only. There is no combinational path from any input to any output.

## Timing
- Reset values: phase=HG, remaining=0, pend_*=0, last_served=0, from_side=0, grant_*=0. The lamps therefore show highway green, country red, walk=0.
- Request latency: req high at edge k sets pending at k. If HG is done, phase=HY at edge k+1.
- A phase loaded with N lasts exactly N ticks plus one clock: remaining reaches 0 on the Nth tick edge and the state changes on the next edge.
- On a state-change edge, load has priority over a coincident tick; that tick is lost.
- Config inputs are sampled only on the state-change edge. Mid-phase changes have no effect until the next entry.
- Emergency during CG/PW exits on the next edge. Emergency during AR goes to HG. HG holds while req_emerg=1, regardless of pending.
- If a request arrives on the same edge its pending is cleared by entry to service, the clear wins. A request still high in the serving state does not re-arm.
- Asynchronous reset mid-phase forces all reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, no requests, 20 ticks → phase=0, hw green, remaining=0 throughout, no grants.
- time_green=3, time_yellow=2, req_country pulsed with HG done → HY(2 ticks)→AR(1)→CG(3)→CY(2)→AR(1)→HG with remaining=3. grant_country pulses exactly once.
- req_country and req_ped both asserted after reset → PW served first. A forced HG follows, then CG. Exactly one grant_ped, then one grant_country.
- req_emerg raised in CG with remaining=2 → next edge CY, then AR, then HG held while emerg=1 with pend_ped=1. Release → HY begins once HG is done.
- time_yellow=0, time_ped=0 with a ped request → HY and PW each last exactly 1 tick.
- reset asserted mid-PW between clock edges → walk=0, phase=0, pending cleared immediately. After release, a new req_ped is served normally.
